ps2_kbd_decode: RTL

PS2_KBD_DECODE -- requirements
Module: ps2_kbd_decode

---
 rtl/ps2_kbd_decode.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_decode.sv
// PS/2 set-2 keyboard decoder: byte-event detection, prefix FSM, shift/ctrl tracking,
// scancode-to-ASCII translation and a small character FIFO with sticky overflow.
//
// state       | meaning
// ST_IDLE     | no prefix pending, next byte is a plain make
// ST_BRK      | F0 seen, next byte is a plain break
// ST_EXT      | E0 seen, next byte is an extended make
// ST_EXT_BRK  | E0 F0 seen, next byte is an extended break

module ps2_kbd_decode #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] scancode,
   input  logic       rdy,
   input  logic       error,
   output logic [6:0] ascii,
   output logic       valid,
   input  logic       ack,
   output logic       overflow,
   output logic       shift,
   output logic       ctrl
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BRK     = 2'd1;
   localparam logic [1:0] ST_EXT     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   logic       rdy_q;
   logic       armed;
   logic       byte_ev;

   logic [1:0] state, state_nxt;
   logic       shift_nxt, ctrl_nxt;
   logic       pend, pend_nxt;
   logic [6:0] pchar, pchar_nxt;

   logic [15:0] map;
   logic        map_hit, map_letter;
   logic [6:0]  map_lo, map_hi, map_char;
   logic        in_brk, in_ext, is_shift_code, is_ctrl_code;

   logic [6:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             pop, push, drop, full;

   // armed blocks a rdy that is already high out of reset from counting as an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
         armed <= 1'b0;
      end else begin
         rdy_q <= rdy;
         if (!rdy) armed <= 1'b1;
      end
   end

   assign byte_ev = rdy & ~rdy_q & armed;

   function automatic logic [15:0] letter(input logic [6:0] lo);
      return {2'b11, lo, lo ^ 7'h20};
   endfunction

   // {hit, is_letter, unshifted, shifted}
   function automatic logic [15:0] key_map(input logic [7:0] code);
      logic [15:0] m;
      m = '0;
      case (code)
         8'h1C: m = letter(7'h61);  8'h32: m = letter(7'h62);
         8'h21: m = letter(7'h63);  8'h23: m = letter(7'h64);
         8'h24: m = letter(7'h65);  8'h2B: m = letter(7'h66);
         8'h34: m = letter(7'h67);  8'h33: m = letter(7'h68);
         8'h43: m = letter(7'h69);  8'h3B: m = letter(7'h6A);
         8'h42: m = letter(7'h6B);  8'h4B: m = letter(7'h6C);
         8'h3A: m = letter(7'h6D);  8'h31: m = letter(7'h6E);
         8'h44: m = letter(7'h6F);  8'h4D: m = letter(7'h70);
         8'h15: m = letter(7'h71);  8'h2D: m = letter(7'h72);
         8'h1B: m = letter(7'h73);  8'h2C: m = letter(7'h74);
         8'h3C: m = letter(7'h75);  8'h2A: m = letter(7'h76);
         8'h1D: m = letter(7'h77);  8'h22: m = letter(7'h78);
         8'h35: m = letter(7'h79);  8'h1A: m = letter(7'h7A);
         8'h45: m = {2'b10, 7'h30, 7'h29};
         8'h16: m = {2'b10, 7'h31, 7'h21};
         8'h1E: m = {2'b10, 7'h32, 7'h40};
         8'h26: m = {2'b10, 7'h33, 7'h23};
         8'h25: m = {2'b10, 7'h34, 7'h24};
         8'h2E: m = {2'b10, 7'h35, 7'h25};
         8'h36: m = {2'b10, 7'h36, 7'h5E};
         8'h3D: m = {2'b10, 7'h37, 7'h26};
         8'h3E: m = {2'b10, 7'h38, 7'h2A};
         8'h46: m = {2'b10, 7'h39, 7'h28};
         8'h0E: m = {2'b10, 7'h60, 7'h7E};
         8'h4E: m = {2'b10, 7'h2D, 7'h5F};
         8'h55: m = {2'b10, 7'h3D, 7'h2B};
         8'h54: m = {2'b10, 7'h5B, 7'h7B};
         8'h5B: m = {2'b10, 7'h5D, 7'h7D};
         8'h5D: m = {2'b10, 7'h5C, 7'h7C};
         8'h4C: m = {2'b10, 7'h3B, 7'h3A};
         8'h52: m = {2'b10, 7'h27, 7'h22};
         8'h41: m = {2'b10, 7'h2C, 7'h3C};
         8'h49: m = {2'b10, 7'h2E, 7'h3E};
         8'h4A: m = {2'b10, 7'h2F, 7'h3F};
         8'h29: m = {2'b10, 7'h20, 7'h20};
         8'h5A: m = {2'b10, 7'h0D, 7'h0D};
         8'h66: m = {2'b10, 7'h7F, 7'h7F};
         8'h76: m = {2'b10, 7'h1B, 7'h1B};
         8'h0D: m = {2'b10, 7'h09, 7'h09};
         default: m = '0;
      endcase
      return m;
   endfunction

   assign map = key_map(scancode);
   assign {map_hit, map_letter, map_lo, map_hi} = map;

   // ctrl on a letter yields the control code and takes priority over shift
   always_comb begin
      map_char = map_lo;
      if (ctrl && map_letter) map_char = map_lo & 7'h1F;
      else if (shift)         map_char = map_hi;
   end

   assign in_brk        = (state == ST_BRK) || (state == ST_EXT_BRK);
   assign in_ext        = (state == ST_EXT) || (state == ST_EXT_BRK);
   assign is_shift_code = (scancode == 8'h12) || (scancode == 8'h59);
   assign is_ctrl_code  = (scancode == 8'h14);

   always_comb begin
      state_nxt = state;
      shift_nxt = shift;
      ctrl_nxt  = ctrl;
      pend_nxt  = 1'b0;
      pchar_nxt = pchar;
      if (byte_ev) begin
         if (error) begin
            state_nxt = ST_IDLE;
         end else if (scancode == 8'hF0) begin
            case (state)
               ST_IDLE: state_nxt = ST_BRK;
               ST_EXT:  state_nxt = ST_EXT_BRK;
               default: state_nxt = ST_IDLE;
            endcase
         end else if (scancode == 8'hE0) begin
            state_nxt = (state == ST_IDLE) ? ST_EXT : ST_IDLE;
         end else begin
            state_nxt = ST_IDLE;
            if (in_brk) begin
               if (is_shift_code && !in_ext) shift_nxt = 1'b0;
               if (is_ctrl_code)             ctrl_nxt  = 1'b0;
            end else if (is_shift_code && !in_ext) begin
               shift_nxt = 1'b1;
            end else if (is_ctrl_code) begin
               ctrl_nxt = 1'b1;
            end else if (!in_ext && map_hit) begin
               pend_nxt  = 1'b1;
               pchar_nxt = map_char;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         shift <= 1'b0;
         ctrl  <= 1'b0;
         pend  <= 1'b0;
         pchar <= 7'h00;
      end else begin
         state <= state_nxt;
         shift <= shift_nxt;
         ctrl  <= ctrl_nxt;
         pend  <= pend_nxt;
         pchar <= pchar_nxt;
      end
   end

   assign full = (count == CNT_FULL);
   assign pop  = ack && (count != '0);
   assign push = pend && (!full || pop);
   assign drop = pend && full && !pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 7'h00;
      end else begin
         if (push) begin
            mem[wr_ptr] <= pchar;
            wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (drop)     overflow <= 1'b1;
         else if (pop) overflow <= 1'b0;
      end
   end

   assign valid = (count != '0);
   assign ascii = valid ? mem[rd_ptr] : 7'h00;

endmodule
